// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: iterative shifter/rotator, one bit per cycle; define SHIFT_ROTATE_UNIT_ARITH_EN for SRA sign fill
module shift_rotate_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] data_q, step_data;
  logic [AMT_W-1:0] cnt_q, amt_c;
  logic [2:0] mode_q;
  logic carry_q, step_carry, fill, left, pass, accept;
  assign accept = in_valid && in_ready;
  generate
    if (WIDTH == 2 ** AMT_W) begin : g_noclamp
      assign amt_c = in_amt;
    end else begin : g_clamp
      assign amt_c = (in_amt > AMT_W'(WIDTH - 1)) ? AMT_W'(WIDTH - 1) : in_amt;
    end
  endgenerate
`ifdef SHIFT_ROTATE_UNIT_ARITH_EN
  assign fill = (mode_q == 3'b010) && data_q[WIDTH-1];
`else
  assign fill = 1'b0;
`endif
  assign left = (mode_q == 3'b000) || (mode_q == 3'b011);
  assign pass = mode_q > 3'b100;
  // mode_q[0] separates ROL (011) from SLL (000) on the left-moving path
  assign step_data = pass ? data_q
                   : left ? {data_q[WIDTH-2:0], mode_q[0] & data_q[WIDTH-1]}
                   : {(mode_q == 3'b100) ? data_q[0] : fill, data_q[WIDTH-1:1]};
  assign step_carry = pass ? carry_q : left ? data_q[WIDTH-1] : data_q[0];
  always_comb begin
    state_nx = (state == IDLE) ? (accept ? BUSY : IDLE)
             : (state == BUSY) ? ((cnt_q == '0) ? DONE : BUSY)
             : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      mode_q    <= '0;
      carry_q   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= state_nx == IDLE;
      out_valid <= state_nx == DONE;
      busy      <= state_nx != IDLE;
      if (accept) begin
        data_q  <= in_data;
        cnt_q   <= amt_c;
        mode_q  <= in_mode;
        carry_q <= 1'b0;
      end else if (state == BUSY && cnt_q != '0) begin
        data_q  <= step_data;
        carry_q <= step_carry;
        cnt_q   <= cnt_q - AMT_W'(1);
      end
    end
  end
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_zero  = data_q == '0;
endmodule
